stall_ctrl: RTL
===============

Name: stall_ctrl

Overview:
- Central pipeline sequencing controller. It collects stall requests from ID (load-use) and EX (multi-cycle mul/div unit) and drives the 6-bit stall bus consumed by PC, IF, ID, EX, MEM and WB.
- It owns the start/ready handshake with the iterative mul/div unit. EX is held until that unit finishes, and each multi-cycle instruction is launched exactly once.
- It enforces a bounded load-use bubble count and a mul/div watchdog.

Parameters:
- LOAD_BUBBLES, 1, number of bubble cycles inserted per load-use hazard (1..3).
- MD_MAX_CYCLES, 64, watchdog limit on cycles spent waiting for md_ready (≥ 2).

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous reset, active-low
- stallreq_for_load  in  1  ID: instruction in ID depends on a load currently in EX
- md_req  in  1  EX: instruction in EX is mult/multu/div/divu
- md_ready  in  1  mul/div unit: result valid (single-cycle pulse)
- md_start  out  1  mul/div unit: launch operation (single-cycle pulse)
- md_busy  out  1  high while an operation is outstanding
- md_timeout  out  1  single-cycle pulse when the watchdog expires
- stall  out  `StallBus (6)  bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB; `Stop=1, `NoStop=0

Behaviour:
- Reset (resetn=0 at posedge):
  - state←IDLE, load_cnt←0, wd_cnt←0.
  - Outputs: stall=6'b000000, md_start=0, md_busy=0, md_timeout=0.
  - A reset during RUN abandons the operation; any later md_ready is ignored in IDLE.
- FSM states: IDLE, RUN, DONE (encodings live in defines.vh).
- IDLE:
  - If md_req=1: md_start=1 combinationally this cycle; stall=6'b001111; next state RUN; wd_cnt←0.
  - Otherwise: load-use logic applies.
- RUN:
  - md_busy=1; stall=6'b001111 (PC..EX held; MEM receives a bubble).
  - Each cycle wd_cnt++.
  - md_ready=1: next state DONE.
  - wd_cnt==MD_MAX_CYCLES-1 without md_ready: md_timeout=1, next state DONE.
  - md_start stays 0 in RUN.
- DONE: exactly one cycle; stall=6'b000000 so EX advances with the result; md_req is ignored this cycle (no relaunch); next state IDLE.
- Back-to-back mul/div: a second md_req arriving in IDLE immediately after DONE launches normally. The minimum md_start spacing is 3 cycles.
- Load-use, evaluated only in IDLE with md_req=0:
  - stallreq_for_load=1 and load_cnt<LOAD_BUBBLES: stall=6'b000111 (PC, IF, ID held; EX bubble); load_cnt++.
  - stallreq_for_load=1 and load_cnt==LOAD_BUBBLES: no stall, request treated as satisfied; load_cnt holds.
  - stallreq_for_load=0: load_cnt←0.
- Simultaneous events:
  - md_req dominates. While EX is held, load_cnt neither increments nor clears, because the load has not moved.
  - md_ready arriving in the same cycle as md_start is ignored. The unit's minimum latency is 1 cycle after start.
- Stall bus invariant: if stall[i]=`Stop then stall[j]=`Stop for all j<i. This is checked by an assertion.
- stall is purely a function of state and inputs; there are no registered outputs except via state.
- Latency: first stall cycle is the same cycle md_req or stallreq_for_load rises. Release is the cycle after md_ready.

Decomposition:
- defines.vh: `StallBus, `Stop/`NoStop, stall pattern constants (STALL_NONE=6'b000000, STALL_LOAD=6'b000111, STALL_EX=6'b001111), FSM state encodings.
- Sub-module md_watchdog (counter with limit compare and expire pulse) is natural. Everything else is inline.

Test Plan:
- Reset: hold resetn=0 for 3 cycles with md_req=1 → stall=0, md_start=0 throughout; first posedge after release with md_req=1 → md_start=1, stall=6'b001111.
- Div with 4-cycle latency: md_req=1 held, md_ready pulses 4 cycles after md_start → exactly one md_start; stall=6'b001111 for 5 cycles, then one cycle of 6'b000000 (DONE); no second md_start.
- Load-use, LOAD_BUBBLES=1: stallreq_for_load=1 held 3 cycles → stall=6'b000111 for 1 cycle, then 6'b000000; load_cnt resets when the request drops.
- Concurrency: md_req and stallreq_for_load both high → stall=6'b001111 until DONE; the following cycle with stallreq_for_load still high → one cycle of 6'b000111.
- Watchdog, MD_MAX_CYCLES=8: md_req=1, md_ready never asserted → md_timeout pulses on the 8th RUN cycle; DONE next cycle; stall cleared.
- Reset mid-RUN: resetn=0 on the 3rd RUN cycle, then md_ready pulse after release with md_req=0 → state IDLE, md_busy=0, no DONE cycle, stall=0.

Source files
------------

// File: rtl/stall_ctrl_pkg.sv
// Shared types and constants for the pipeline stall controller.
//   stall_bus_t : one bit per stage, bit0 PC .. bit5 WB
//   state_t     : mul/div sequencing states
//   stall_is_prefix() : true when every Stop bit has only Stop bits below it
package stall_ctrl_pkg;

   localparam int STALL_W = 6;

   typedef logic [STALL_W-1:0] stall_bus_t;

   localparam logic STOP    = 1'b1;
   localparam logic NO_STOP = 1'b0;

   localparam stall_bus_t STALL_NONE = 6'b000000;
   localparam stall_bus_t STALL_LOAD = 6'b000111;
   localparam stall_bus_t STALL_EX   = 6'b001111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // A legal stall bus is a contiguous run of ones starting at bit0.
   function automatic logic stall_is_prefix(input stall_bus_t s);
      return (s & (s + 6'd1)) == STALL_NONE;
   endfunction

endpackage

// File: rtl/stall_ctrl_md_watchdog.sv
// Mul/div watchdog: down-counter loaded when an operation launches,
// decremented on every waiting cycle, expires on terminal count.
//   clk, resetn : clock, synchronous active-low reset
//   start       : load the counter (launch cycle)
//   run         : an operation is outstanding this cycle
//   expire      : run is high and this is the MAX_CYCLES-th waiting cycle
module stall_ctrl_md_watchdog #(
   parameter int MAX_CYCLES = 64
) (
   input  logic clk,
   input  logic resetn,
   input  logic start,
   input  logic run,
   output logic expire
);

   localparam int CNT_W = (MAX_CYCLES > 2) ? $clog2(MAX_CYCLES) : 1;
   localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(MAX_CYCLES - 1);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         cnt <= '0;
      end else if (start) begin
         cnt <= LOAD_VAL;
      end else if (run && (cnt != '0)) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign expire = run && (cnt == '0);

endmodule

// File: rtl/stall_ctrl.sv
// Pipeline stall controller: merges load-use and mul/div stall requests
// into the 6-bit stall bus, owns the md_start/md_ready handshake and the
// mul/div watchdog.
//   clk, resetn        : clock, synchronous active-low reset
//   stallreq_for_load  : ID depends on a load currently in EX
//   md_req             : EX holds a mult/multu/div/divu
//   md_ready           : mul/div result valid (pulse)
//   md_start           : launch pulse to the mul/div unit
//   md_busy            : operation outstanding
//   md_timeout         : watchdog expiry pulse
//   stall              : bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | no mul/div outstanding; launches on md_req, else load-use
// RUN     | waiting for md_ready or watchdog; PC..EX held
// DONE    | one cycle, EX advances with the result; md_req ignored
module stall_ctrl
   import stall_ctrl_pkg::*;
#(
   parameter int LOAD_BUBBLES  = 1,
   parameter int MD_MAX_CYCLES = 64
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             stallreq_for_load,
   input  logic             md_req,
   input  logic             md_ready,
   output logic             md_start,
   output logic             md_busy,
   output logic             md_timeout,
   output logic [STALL_W-1:0] stall
);

   localparam logic [1:0] LOAD_LIM = 2'(LOAD_BUBBLES);

   state_t     state, state_n;
   logic [1:0] load_cnt, load_cnt_n;
   logic       wd_start, wd_run, wd_expire;

   stall_ctrl_md_watchdog #(.MAX_CYCLES(MD_MAX_CYCLES)) u_wd (
      .clk    (clk),
      .resetn (resetn),
      .start  (wd_start),
      .run    (wd_run),
      .expire (wd_expire)
   );

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state    <= ST_IDLE;
         load_cnt <= 2'd0;
      end else begin
         state    <= state_n;
         load_cnt <= load_cnt_n;
      end
   end

   // Outputs are forced quiet while reset is asserted so a held md_req
   // cannot launch an operation during reset.
   always_comb begin
      state_n    = state;
      load_cnt_n = load_cnt;
      stall      = STALL_NONE;
      md_start   = 1'b0;
      md_busy    = 1'b0;
      md_timeout = 1'b0;
      wd_start   = 1'b0;
      wd_run     = 1'b0;
      if (!resetn) begin
         state_n = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: begin
               if (md_req) begin
                  md_start = 1'b1;
                  wd_start = 1'b1;
                  stall    = STALL_EX;
                  state_n  = ST_RUN;
               end else if (stallreq_for_load) begin
                  if (load_cnt < LOAD_LIM) begin
                     stall      = STALL_LOAD;
                     load_cnt_n = load_cnt + 2'd1;
                  end
               end else begin
                  load_cnt_n = 2'd0;
               end
            end
            ST_RUN: begin
               md_busy = 1'b1;
               wd_run  = 1'b1;
               stall   = STALL_EX;
               if (md_ready) begin
                  state_n = ST_DONE;
               end else if (wd_expire) begin
                  md_timeout = 1'b1;
                  state_n    = ST_DONE;
               end
            end
            ST_DONE: begin
               state_n = ST_IDLE;
            end
            default: begin
               state_n = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (resetn) begin
         assert (stall_is_prefix(stall));
      end
   end

endmodule
